// File: rtl/tilelink_arbiter2.sv
// Two-master TileLink-UL arbiter in front of block_ram: round-robin or fixed
// priority grant, zero-latency request forwarding, response steering by owner.
package tilelink_pkg;
  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_GET         = 3'd4;
  localparam logic [2:0] TL_ACK         = 3'd0;
  localparam logic [2:0] TL_ACK_DATA    = 3'd1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
  } tilelink_a;

  typedef struct packed {
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [3:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
  } tilelink_d;
endpackage

module tilelink_arbiter2
  import tilelink_pkg::*;
#(
  parameter bit          fixed_priority = 1'b0,
  parameter logic [31:0] addr_mask      = 32'hF0000000,
  parameter logic [31:0] addr_tag       = 32'h00000000
) (
  input  logic      clock,
  input  logic      reset,
  input  tilelink_a tla0,
  input  tilelink_a tla1,
  output tilelink_d tld0,
  output tilelink_d tld1,
  output tilelink_a ram_tla,
  input  tilelink_d ram_tld,
  output logic      stray_resp
);
  logic       rr_next_q, rr_next_d;
  logic       pend_valid_q, pend_valid_d;
  logic       pend_owner_q, pend_owner_d;
  logic       pend_local_err_q, pend_local_err_d;
  logic [3:0] pend_source_q, pend_source_d;
  logic [2:0] pend_size_q, pend_size_d;
  logic       stray_q, stray_d;

  logic      win, hit, accept;
  tilelink_a win_tla;
  tilelink_d resp, idle;

  // Grant is always shown, even with no requester, so a master raising
  // a_valid can be accepted in the same cycle.
  always_comb begin
    win = fixed_priority ? 1'b0 : rr_next_q;
    if (tla0.a_valid && !tla1.a_valid)      win = 1'b0;
    else if (tla1.a_valid && !tla0.a_valid) win = 1'b1;
    win_tla         = win ? tla1 : tla0;
    hit             = (win_tla.a_address & addr_mask) == addr_tag;
    accept          = win_tla.a_valid && !reset;
    ram_tla         = win_tla;
    ram_tla.a_valid = accept && hit;
  end

  always_comb begin
    rr_next_d        = rr_next_q;
    pend_valid_d     = accept;
    pend_owner_d     = win;
    pend_local_err_d = !hit;
    pend_source_d    = win_tla.a_source;
    pend_size_d      = win_tla.a_size;
    if (accept) rr_next_d = !win;
    // Unowned RAM beats are dropped but remembered.
    stray_d = stray_q || (ram_tld.d_valid && (!pend_valid_q || pend_local_err_q));
  end

  always_comb begin
    idle         = 'x;
    idle.d_valid = 1'b0;
    idle.d_error = 1'b0;
    idle.d_ready = 1'b0;
    resp         = ram_tld;
    if (pend_local_err_q) begin
      resp.d_opcode = TL_ACK_DATA;
      resp.d_param  = '0;
      resp.d_size   = pend_size_q;
      resp.d_source = pend_source_q;
      resp.d_sink   = 1'b0;
      resp.d_data   = '0;
      resp.d_error  = 1'b1;
    end
    resp.d_valid = 1'b1;
    resp.d_ready = 1'b0;
    tld0 = idle;
    tld1 = idle;
    if (pend_valid_q && !reset) begin
      if (pend_owner_q) tld1 = resp;
      else              tld0 = resp;
    end
    tld0.d_ready = !reset && !win;
    tld1.d_ready = !reset && win;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_next_q        <= 1'b0;
      pend_valid_q     <= 1'b0;
      pend_owner_q     <= 1'b0;
      pend_local_err_q <= 1'b0;
      pend_source_q    <= '0;
      pend_size_q      <= '0;
      stray_q          <= 1'b0;
    end else begin
      rr_next_q        <= rr_next_d;
      pend_valid_q     <= pend_valid_d;
      pend_owner_q     <= pend_owner_d;
      pend_local_err_q <= pend_local_err_d;
      pend_source_q    <= pend_source_d;
      pend_size_q      <= pend_size_d;
      stray_q          <= stray_d;
    end
  end

  assign stray_resp = stray_q;
endmodule
